// File: rtl/alu_rr_arbiter.sv
// Round-robin front end that shares one add/sub ALU between two requesters.
// One operation in flight: IDLE accepts, EXEC drives the ALU, RESP holds the result.
module alu_rr_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_src_1,
  input  logic [DATA_W-1:0] req0_src_2,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_src_1,
  input  logic [DATA_W-1:0] req1_src_2,
  output logic [DATA_W-1:0] alu_src_1,
  output logic [DATA_W-1:0] alu_src_2,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_result,
  output logic              resp0_carry,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_result,
  output logic              resp1_carry
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_last_grant;
  logic              r_owner;
  logic [OP_W-1:0]   r_op;
  logic [DATA_W-1:0] r_src_1;
  logic [DATA_W-1:0] r_src_2;
  logic [DATA_W-1:0] r_result;
  logic              r_carry;
  logic              w_grant;
  logic              w_accept;
  logic              w_resp_ready;

  // Tie goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last_grant;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign w_accept     = (r_state == IDLE) && (req0_valid || req1_valid);
  assign w_resp_ready = r_owner ? resp1_ready : resp0_ready;

  assign req0_ready = w_accept && !w_grant;
  assign req1_ready = w_accept &&  w_grant;

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next_state = EXEC;
      EXEC:    w_next_state = RESP;
      RESP:    if (w_resp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_op         <= '0;
      r_src_1      <= '0;
      r_src_2      <= '0;
      r_result     <= '0;
      r_carry      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_owner      <= w_grant;
        r_last_grant <= w_grant;
        r_op         <= w_grant ? req1_op    : req0_op;
        r_src_1      <= w_grant ? req1_src_1 : req0_src_1;
        r_src_2      <= w_grant ? req1_src_2 : req0_src_2;
      end
      if (r_state == EXEC) begin
        r_result <= alu_result;
        r_carry  <= alu_carry;
      end
    end
  end

  // ALU inputs are zero outside EXEC so op 0 keeps the ALU output quiet.
  assign alu_op    = (r_state == EXEC) ? r_op    : '0;
  assign alu_src_1 = (r_state == EXEC) ? r_src_1 : '0;
  assign alu_src_2 = (r_state == EXEC) ? r_src_2 : '0;

  assign resp0_valid  = (r_state == RESP) && !r_owner;
  assign resp1_valid  = (r_state == RESP) &&  r_owner;
  assign resp0_result = r_result;
  assign resp1_result = r_result;
  assign resp0_carry  = r_carry;
  assign resp1_carry  = r_carry;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Randomized scoreboard bench for alu_rr_arbiter with a behavioural ALU and
// a transaction-level model of arbitration and response timing.
module tb_alu_rr_arbiter;

  localparam logic [5:0] OP_ADD = 6'b001001;
  localparam logic [5:0] OP_SUB = 6'b001010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [5:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_src_1 = '0, req0_src_2 = '0, req1_src_1 = '0, req1_src_2 = '0;
  logic [31:0] alu_src_1, alu_src_2, alu_result;
  logic [5:0]  alu_op;
  logic        alu_carry;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [31:0] resp0_result, resp1_result;
  logic        resp0_carry, resp1_carry;
  logic [32:0] alu_sum;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.DATA_W(32), .OP_W(6)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_src_1(req0_src_1), .req0_src_2(req0_src_2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_src_1(req1_src_1), .req1_src_2(req1_src_2),
    .alu_src_1(alu_src_1), .alu_src_2(alu_src_2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_result(resp0_result), .resp0_carry(resp0_carry),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_result(resp1_result), .resp1_carry(resp1_carry)
  );

  // Behavioural ALU: 33-bit add/sub, bit 32 is carry-out or borrow.
  always_comb begin
    alu_sum = 33'd0;
    case (alu_op)
      OP_ADD:  alu_sum = {1'b0, alu_src_1} + {1'b0, alu_src_2};
      OP_SUB:  alu_sum = {1'b0, alu_src_1} - {1'b0, alu_src_2};
      default: alu_sum = 33'd0;
    endcase
  end
  assign alu_result = alu_sum[31:0];
  assign alu_carry  = alu_sum[32];

  typedef struct { logic [5:0] op; logic [31:0] a; logic [31:0] b; } req_t;
  typedef struct { int owner; logic [31:0] res; logic c; } exp_t;

  exp_t sb[$];
  req_t dq0[$], dq1[$];
  req_t pr[2];
  bit   pv[2];
  int   total = 0, bad = 0;

  bit   m_busy = 1'b0;
  int   m_cnt = 0, m_owner = 0, m_last = 1;
  req_t m_req;
  bit   allow_new = 1'b1;
  int   rate = 100, rdy_pct = 100;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      default: return $urandom();
    endcase
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int   k = int'($urandom_range(9));
    r.op = (k < 4) ? OP_ADD : (k < 8) ? OP_SUB : 6'($urandom_range(63));
    r.a  = pick_val();
    r.b  = pick_val();
    return r;
  endfunction

  // Reference: wrap-around arithmetic, carry from unsigned overflow, borrow from a<b.
  function automatic exp_t ref_model(input int o, input req_t q);
    exp_t e;
    e.owner = o;
    e.res   = '0;
    e.c     = 1'b0;
    if (q.op == OP_ADD) begin
      e.res = q.a + q.b;
      e.c   = (e.res < q.a);
    end else if (q.op == OP_SUB) begin
      e.res = q.a - q.b;
      e.c   = (q.a < q.b);
    end
    return e;
  endfunction

  function automatic req_t mk(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    req_t r;
    r.op = op; r.a = a; r.b = b;
    return r;
  endfunction

  task automatic drive_reqs();
    req0_valid = pv[0]; req0_op = pr[0].op; req0_src_1 = pr[0].a; req0_src_2 = pr[0].b;
    req1_valid = pv[1]; req1_op = pr[1].op; req1_src_1 = pr[1].a; req1_src_2 = pr[1].b;
  endtask

  task automatic step();
    bit any;
    int g;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!pv[i] && allow_new) begin
        if (i == 0 && dq0.size() > 0) begin pr[0] = dq0.pop_front(); pv[0] = 1'b1; end
        else if (i == 1 && dq1.size() > 0) begin pr[1] = dq1.pop_front(); pv[1] = 1'b1; end
        else if (int'($urandom_range(99)) < rate) begin pr[i] = rand_req(); pv[i] = 1'b1; end
      end
    end
    drive_reqs();
    resp0_ready = (int'($urandom_range(99)) < rdy_pct);
    resp1_ready = (int'($urandom_range(99)) < rdy_pct);
    #1;
    any = pv[0] || pv[1];
    g   = (pv[0] && pv[1]) ? 1 - m_last : (pv[1] ? 1 : 0);
    chk("req0_ready", 32'(req0_ready), 32'(!m_busy && any && g == 0));
    chk("req1_ready", 32'(req1_ready), 32'(!m_busy && any && g == 1));
    chk("resp0_valid", 32'(resp0_valid), 32'(m_busy && m_cnt >= 1 && m_owner == 0));
    chk("resp1_valid", 32'(resp1_valid), 32'(m_busy && m_cnt >= 1 && m_owner == 1));
    if (m_busy && m_cnt == 0) begin
      chk("alu_op_exec", 32'(alu_op), 32'(m_req.op));
      chk("alu_src_1", alu_src_1, m_req.a);
      chk("alu_src_2", alu_src_2, m_req.b);
    end else begin
      chk("alu_op_quiet", 32'(alu_op), 32'd0);
    end
    if (m_busy) begin
      if (m_cnt >= 1 && (m_owner == 0 ? resp0_ready : resp1_ready)) m_busy = 1'b0;
      else m_cnt++;
    end else if (any) begin
      m_busy  = 1'b1;
      m_cnt   = 0;
      m_owner = g;
      m_last  = g;
      m_req   = pr[g];
      sb.push_back(ref_model(g, pr[g]));
    end
    if (req0_valid && req0_ready) pv[0] = 1'b0;
    if (req1_valid && req1_ready) pv[1] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pv[0] = 1'b0; pv[1] = 1'b0;
    drive_reqs();
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    #1;
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
    chk("rst_resp0_valid", 32'(resp0_valid), 32'd0);
    chk("rst_resp1_valid", 32'(resp1_valid), 32'd0);
    chk("rst_resp0_result", resp0_result, 32'd0);
    chk("rst_resp1_result", resp1_result, 32'd0);
    chk("rst_resp_carry", 32'({resp1_carry, resp0_carry}), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_src", alu_src_1 | alu_src_2, 32'd0);
    m_busy = 1'b0;
    m_last = 1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic mon(input int o, input logic [31:0] r, input logic c, input logic rdy);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL resp_unexpected t=%0t owner=%0d got=%h expected=none", $time, o, r);
    end else begin
      chk("resp_owner", 32'(o), 32'(sb[0].owner));
      chk("resp_result", r, sb[0].res);
      chk("resp_carry", 32'(c), 32'(sb[0].c));
      if (rdy) void'(sb.pop_front());
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (resp0_valid) mon(0, resp0_result, resp0_carry, resp0_ready);
        if (resp1_valid) mon(1, resp1_result, resp1_carry, resp1_ready);
      end
    end
  end

  initial begin
    int guard;
    pv[0] = 1'b0; pv[1] = 1'b0;
    pr[0] = mk(6'd0, 32'd0, 32'd0);
    pr[1] = pr[0];
    m_req = pr[0];
    do_reset();

    dq0.push_back(mk(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001));
    dq0.push_back(mk(6'b000000, 32'd7, 32'd9));
    dq1.push_back(mk(OP_SUB, 32'd3, 32'd5));
    dq1.push_back(mk(OP_SUB, 32'd5, 32'd3));
    rate = 100; rdy_pct = 100;
    repeat (30) step();

    rate = 100; rdy_pct = 20;
    repeat (300) step();

    rate = 50; rdy_pct = 70;
    repeat (1500) step();

    rate = 100; rdy_pct = 100;
    guard = 0;
    do begin
      step();
      guard++;
    end while (!(m_busy && m_cnt == 0) && guard < 50);
    chk("reach_exec", 32'(m_busy && m_cnt == 0), 32'd1);
    do_reset();
    repeat (20) step();

    rate = 60; rdy_pct = 60;
    repeat (300) step();

    allow_new = 1'b0; rdy_pct = 100;
    guard = 0;
    while ((m_busy || pv[0] || pv[1]) && guard < 40) begin
      step();
      guard++;
    end
    repeat (2) step();
    chk("drain_idle", 32'(m_busy || pv[0] || pv[1]), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
Shares the single 32-bit add/sub ALU between two requesters (e.g. execute stage and address-generation unit) using round-robin arbitration.
Each requester issues {op, operands} on a valid/ready handshake and receives {result, carry} on a separate valid/ready response channel.
One operation is in flight at a time; the ALU is driven from registered operands and its combinational output is captured into a response register.

Parameters:
DATA_W, 32, operand/result width; must match the ALU datapath
OP_W, 6, operation code width; 6'b001001 = addu, 6'b001010 = subu, all other codes yield result 0 / carry 0 in the ALU

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle when valid&ready
req0_op  input  OP_W  requester 0 operation code
req0_src_1  input  DATA_W  requester 0 first operand
req0_src_2  input  DATA_W  requester 0 second operand
req1_valid / req1_ready / req1_op / req1_src_1 / req1_src_2  same as above for requester 1
alu_src_1  output  DATA_W  to ALU Src_1
alu_src_2  output  DATA_W  to ALU Src_2
alu_op  output  OP_W  to ALU OP_ctrl
alu_result  input  DATA_W  from ALU ALU_Result
alu_carry  input  1  from ALU ALU_Carry
resp0_valid  output  1  result for requester 0 available
resp0_ready  input  1  requester 0 consumes result when valid&ready
resp0_result  output  DATA_W  captured result
resp0_carry  output  1  captured carry/borrow
resp1_valid / resp1_ready / resp1_result / resp1_carry  same as above for requester 1

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset (async, rst=1) -> IDLE, last_grant=1 (requester 0 wins the first tie), all outputs 0: req*_ready=0, resp*_valid=0, resp*_result=0, resp*_carry=0, alu_src_*=0, alu_op=0.
- IDLE: grant is combinational. Only one valid -> that requester. Both valid -> the requester not equal to last_grant. req_ready of the granted requester = 1 only in IDLE; the other ready = 0. Neither valid -> both ready = 0.
- Accept (valid&ready, IDLE): latch op/src_1/src_2 and owner ID into operand registers; last_grant <= owner; -> EXEC.
- EXEC (exactly 1 cycle): alu_op/alu_src_* driven from operand registers. At the clock edge: resp_result <= alu_result, resp_carry <= alu_carry; -> RESP.
- In IDLE and RESP, alu_op = 0, which selects the ALU default (output 0). This isolates the ALU and saves power.
- RESP: resp<owner>_valid=1 and the other resp valid=0. Data is held stable while valid and not ready. On resp_ready -> IDLE, valid drops next cycle.
- Latency: accept edge N; EXEC during cycle N+1; resp_valid asserted from cycle N+2. Minimum issue interval per ALU is 3 cycles (accept, exec, resp handshake).
- A new request is never accepted in RESP, so there is no overlap and no response buffering.
- Arithmetic: no interpretation of the result. Carry is passed verbatim (addu carry-out, subu borrow bit 32 of the difference). Unknown op codes complete normally with result 0, carry 0.
- Requesters must hold valid/op/operands stable until ready. If valid drops before ready, the request is not recorded.
- rst asserted in EXEC or RESP: the in-flight operation is discarded with no response, and all outputs return to reset values immediately.

Test Plan:
- Single add: req0 addu 0xFFFFFFFF + 0x00000001, resp0_ready=1 -> req0_ready in cycle 0, resp0_valid in cycle 2 with result 0x00000000, carry 1; resp1_valid stays 0.
- Subtract with borrow: req1 subu 0x00000003 - 0x00000005 -> resp1_result 0xFFFFFFFE, resp1_carry 1; subu 5 - 3 -> result 0x00000002, carry 0.
- Fairness: both valid continuously after reset, 4 ops -> grant order 0,1,0,1. Each response is routed only to its owner, and no second accept occurs before the prior response handshake.
- Backpressure: resp0_ready held 0 for 5 cycles -> resp0_valid/result/carry stable. req1_valid=1 throughout but req1_ready=0 until the cycle after resp0 handshake.
- Unknown op 6'b000000 with operands 7, 9 -> response result 0, carry 0, normal 3-cycle flow. alu_op=0 whenever the FSM is not in EXEC.
- Reset mid-operation: assert rst during EXEC -> no resp valid ever appears for that op; next cycle all outputs are 0. After release, requester 0 wins a simultaneous request.
